instruction_sequencer: RTL

Instruction sequencer that drives the 6-bit `state` input of the processor's `control_unit`. It steps through the fetch phase, decodes the fetched opcode, walks the matching execute phase, and returns to fetch or idle. It also provides start/stop/done handshakes to the top level and counts decoded instructions.

---
 rtl/instruction_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: walks fetch, decodes the IR opcode, runs the execute
// phase and produces the 6-bit state code consumed by control_unit.
module instruction_sequencer #(
  parameter int OPC_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [OPC_W-1:0]   opcode,
  output logic [5:0]         state,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  // State codes are fixed by the control_unit decode table.
  localparam logic [5:0] S_IDLE   = 6'd0;
  localparam logic [5:0] S_FETCH1 = 6'd1;
  localparam logic [5:0] S_FETCH2 = 6'd2;
  localparam logic [5:0] S_FETCH3 = 6'd3;
  localparam logic [5:0] S_FETCH4 = 6'd4;
  localparam logic [5:0] S_FETCH5 = 6'd5;
  localparam logic [5:0] S_FETCH6 = 6'd6;
  localparam logic [5:0] S_LDR11  = 6'd7;
  localparam logic [5:0] S_LDR12  = 6'd8;
  localparam logic [5:0] S_LDR13  = 6'd9;
  localparam logic [5:0] S_LDR14  = 6'd10;
  localparam logic [5:0] S_LDR21  = 6'd11;
  localparam logic [5:0] S_LDR22  = 6'd12;
  localparam logic [5:0] S_LDR23  = 6'd13;
  localparam logic [5:0] S_LDR24  = 6'd14;
  localparam logic [5:0] S_STAC1  = 6'd15;
  localparam logic [5:0] S_STAC2  = 6'd16;
  localparam logic [5:0] S_STAC3  = 6'd17;
  localparam logic [5:0] S_STAC4  = 6'd18;
  localparam logic [5:0] S_ADD    = 6'd19;
  localparam logic [5:0] S_MUL    = 6'd20;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_LDR1 = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LDR2 = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_STAC = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_END  = OPC_W'(15);

  localparam int OPC_N = 1 << OPC_W;

  logic [5:0]         state_reg, state_next;
  logic               done_reg, done_next;
  logic               aborted_reg, aborted_next;
  logic               illegal_reg, illegal_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic [OPC_N-1:0]   opc_legal;
  logic               opcode_legal;
  logic               boundary;
  logic               end_decoded;
  logic               in_fetch6;

  // Legality table indexed by opcode value.
  generate
    for (genvar gi = 0; gi < OPC_N; gi++) begin : g_legal
      assign opc_legal[gi] = (gi <= 5) || (gi == 15);
    end
  endgenerate

  assign opcode_legal = opc_legal[opcode];
  assign in_fetch6    = (state_reg == S_FETCH6);

  always_comb begin
    state_next  = state_reg;
    boundary    = 1'b0;
    end_decoded = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH1;
      end
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_FETCH5,
      S_LDR11, S_LDR12, S_LDR13,
      S_LDR21, S_LDR22, S_LDR23,
      S_STAC1, S_STAC2, S_STAC3: begin
        state_next = state_reg + 6'd1;
      end
      S_FETCH6: begin
        case (opcode)
          OP_LDR1: state_next = S_LDR11;
          OP_LDR2: state_next = S_LDR21;
          OP_STAC: state_next = S_STAC1;
          OP_ADD:  state_next = S_ADD;
          OP_MUL:  state_next = S_MUL;
          OP_END: begin
            state_next  = S_IDLE;
            end_decoded = 1'b1;
          end
          default: boundary = 1'b1;  // NOP and undefined opcodes
        endcase
      end
      S_LDR14, S_LDR24, S_STAC4, S_ADD, S_MUL: begin
        boundary = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    // stop is only looked at on an instruction boundary; END wins over it.
    if (boundary) state_next = stop ? S_IDLE : S_FETCH1;
  end

  always_comb begin
    aborted_next = boundary && stop;
    done_next    = end_decoded || aborted_next;
    illegal_next = in_fetch6 && !opcode_legal;
    count_next   = in_fetch6 ? count_reg + COUNT_W'(1) : count_reg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      done_reg    <= 1'b0;
      aborted_reg <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      done_reg    <= done_next;
      aborted_reg <= aborted_next;
      illegal_reg <= illegal_next;
      count_reg   <= count_next;
    end
  end

  assign state       = state_reg;
  assign busy        = (state_reg != S_IDLE);
  assign done        = done_reg;
  assign aborted     = aborted_reg;
  assign illegal     = illegal_reg;
  assign instr_count = count_reg;

endmodule
